// File: rtl/dm_block_engine_if.sv
// Command, stream-out and data-memory port bundle for dm_block_engine.
// The engine takes the slave side; the host owns the memory and takes the master side.
interface dm_block_engine_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_data;
  logic              dm_wren;
  logic [DATA_W-1:0] dm_q;

  modport slave (
    input  start, op, src, dst, len, fill_value, dm_q,
    output busy, done, rd_valid, rd_data, dm_address, dm_data, dm_wren
  );

  modport master (
    output start, op, src, dst, len, fill_value, dm_q,
    input  busy, done, rd_valid, rd_data, dm_address, dm_data, dm_wren
  );
endinterface

// File: rtl/dm_block_engine.sv
// Block fill / copy / dump initiator for the 16 x 4-bit data memory.
// Every output is registered so the memory sees stable values at its negedge write.
module dm_block_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  dm_block_engine_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_RD, S_CAP, S_WR, S_DADDR, S_DWAIT, S_DCAP, S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wren;
  logic              r_busy;
  logic              r_done;
  logic              r_rdValid;
  logic [DATA_W-1:0] r_rdData;

  logic              w_accept;
  logic              w_isLast;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_wren;
  logic              w_busy;
  logic              w_done;
  logic              w_rdValid;
  logic [DATA_W-1:0] w_rdData;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_isLast = (r_idx == r_last);

  // len-1 wraps 0 to 15, so a zero length naturally runs all 16 elements
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_last    <= '0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wren    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_idx     <= w_idx;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_wren    <= w_wren;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_rdValid <= w_rdValid;
      r_rdData  <= w_rdData;
      if (w_accept) begin
        r_src  <= bus.src;
        r_dst  <= bus.dst;
        r_last <= bus.len - ADDR_W'(1);
        r_fill <= bus.fill_value;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b00:   w_nextState = S_FILL;
            2'b01:   w_nextState = S_RD;
            2'b10:   w_nextState = S_DADDR;
            default: w_nextState = S_FIN;
          endcase
        end
      end
      S_FILL:  w_nextState = w_isLast ? S_FIN : S_FILL;
      S_RD:    w_nextState = S_CAP;
      S_CAP:   w_nextState = S_WR;
      S_WR:    w_nextState = w_isLast ? S_FIN : S_RD;
      S_DADDR: w_nextState = S_DWAIT;
      S_DWAIT: w_nextState = S_DCAP;
      S_DCAP:  w_nextState = w_isLast ? S_FIN : S_DWAIT;
      S_FIN:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // dm_q carries the word addressed two edges earlier, which is what WR and DCAP consume
  always_comb begin
    w_idx     = r_idx;
    w_addr    = r_addr;
    w_data    = r_data;
    w_wren    = 1'b0;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_rdValid = 1'b0;
    w_rdData  = r_rdData;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_busy = 1'b1;
          w_idx  = '0;
        end
      end
      S_FILL: begin
        w_addr = r_dst + r_idx;
        w_data = r_fill;
        w_wren = 1'b1;
        w_idx  = r_idx + ADDR_W'(1);
      end
      S_RD: begin
        w_addr = r_src + r_idx;
      end
      S_WR: begin
        w_addr = r_dst + r_idx;
        w_data = bus.dm_q;
        w_wren = 1'b1;
        w_idx  = r_idx + ADDR_W'(1);
      end
      S_DADDR: begin
        w_addr = r_src;
      end
      S_DCAP: begin
        w_rdData  = bus.dm_q;
        w_rdValid = 1'b1;
        w_addr    = r_src + r_idx + ADDR_W'(1);
        w_idx     = r_idx + ADDR_W'(1);
      end
      S_FIN: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: begin
        w_busy = r_busy;
      end
    endcase
  end

  assign bus.dm_address = r_addr;
  assign bus.dm_data    = r_data;
  assign bus.dm_wren    = r_wren;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rd_valid   = r_rdValid;
  assign bus.rd_data    = r_rdData;

endmodule

// File: tb/tb_dm_block_engine.sv
// Directed bench for dm_block_engine with a behavioural 16 x 4 memory model
// (negedge write, registered posedge q) and a single checking task.
module tb_dm_block_engine;

  logic clock;
  logic reset;
  logic initReq;

  dm_block_engine_if bus ();

  dm_block_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] mem [16];
  int         checkCount;
  int         passCount;
  int         doneAt;
  logic [3:0] rdQ [$];
  int         rdAt [$];
  logic [3:0] expQ [$];
  logic       wrenSeen;
  logic       busyDropped;
  logic       doneSeen;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model: write on negedge, registered read on posedge with write-through
  always @(negedge clock) begin
    if (initReq) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(15 - i);
    end else if (bus.dm_wren) begin
      mem[bus.dm_address] <= bus.dm_data;
    end
  end

  always @(posedge clock) begin
    bus.dm_q <= bus.dm_wren ? bus.dm_data : mem[bus.dm_address];
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, actual, actual, expected, expected);
  endtask

  task automatic initMem();
    @(posedge clock);
    initReq = 1'b1;
    @(negedge clock);
    #1 initReq = 1'b0;
  endtask

  // issue one command and follow it edge by edge until done (bounded)
  task automatic applyStimulus(input logic [1:0] cOp, input logic [3:0] cSrc,
                               input logic [3:0] cDst, input logic [3:0] cLen,
                               input logic [3:0] cFill);
    @(negedge clock);
    bus.start      = 1'b1;
    bus.op         = cOp;
    bus.src        = cSrc;
    bus.dst        = cDst;
    bus.len        = cLen;
    bus.fill_value = cFill;
    @(posedge clock);
    #1 bus.start = 1'b0;
    doneAt      = -1;
    rdQ.delete();
    rdAt.delete();
    wrenSeen    = 1'b0;
    busyDropped = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock);
      #1;
      if (bus.rd_valid) begin
        rdQ.push_back(bus.rd_data);
        rdAt.push_back(k);
      end
      if (bus.dm_wren) wrenSeen = 1'b1;
      if (bus.done) begin
        doneAt = k;
        break;
      end
      if (!bus.busy) busyDropped = 1'b1;
    end
    if (doneAt < 0) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic checkDump(input string tag, input logic [3:0] s, input logic [3:0] l);
    int n;
    n = (l == 4'd0) ? 16 : int'(l);
    applyStimulus(2'b10, s, 4'd0, l, 4'd0);
    checkOutput({tag, "_count"}, rdQ.size(), expQ.size());
    for (int i = 0; i < rdQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_d%0d", tag, i), int'(rdQ[i]), int'(expQ[i]));
    checkOutput({tag, "_doneAt"}, doneAt, 2 * n + 2);
  endtask

  initial begin
    checkCount     = 0;
    passCount      = 0;
    initReq        = 1'b1;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.src        = 4'd0;
    bus.dst        = 4'd0;
    bus.len        = 4'd0;
    bus.fill_value = 4'd0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstBusy",  int'(bus.busy),       0);
    checkOutput("rstDone",  int'(bus.done),       0);
    checkOutput("rstValid", int'(bus.rd_valid),   0);
    checkOutput("rstWren",  int'(bus.dm_wren),    0);
    checkOutput("rstAddr",  int'(bus.dm_address), 0);
    @(negedge clock);
    reset   = 1'b0;
    initReq = 1'b0;

    $display("[TB] full dump of power-up memory");
    applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("fullDump_count", rdQ.size(), 16);
    for (int i = 0; i < rdQ.size() && i < 16; i++) begin
      checkOutput($sformatf("fullDump_d%0d", i), int'(rdQ[i]), 15 - i);
      checkOutput($sformatf("fullDump_t%0d", i), rdAt[i], 3 + 2 * i);
    end
    checkOutput("fullDump_doneAt", doneAt, 34);
    checkOutput("fullDump_wren", int'(wrenSeen), 0);

    $display("[TB] fill dst=4 len=3 value=A");
    applyStimulus(2'b00, 4'd0, 4'd4, 4'd3, 4'hA);
    checkOutput("fill_doneAt", doneAt, 4);
    expQ = '{4'hC, 4'hA, 4'hA, 4'hA, 4'h8};
    checkDump("fillRead", 4'd3, 4'd5);

    $display("[TB] copy src=0 dst=8 len=4");
    initMem();
    applyStimulus(2'b01, 4'd0, 4'd8, 4'd4, 4'd0);
    checkOutput("copy_doneAt", doneAt, 13);
    checkOutput("copy_busyGap", int'(busyDropped), 0);
    expQ = '{4'hF, 4'hE, 4'hD, 4'hC};
    checkDump("copyRead", 4'd8, 4'd4);

    $display("[TB] wrapping fill dst=E len=4 value=5");
    initMem();
    applyStimulus(2'b00, 4'd0, 4'hE, 4'd4, 4'h5);
    checkOutput("wrapFill_doneAt", doneAt, 5);
    expQ = '{4'h5, 4'h5, 4'h5, 4'h5, 4'hD};
    checkDump("wrapRead", 4'hE, 4'd5);

    $display("[TB] overlapping copy src=0 dst=1 len=3");
    initMem();
    applyStimulus(2'b01, 4'd0, 4'd1, 4'd3, 4'd0);
    checkOutput("overlap_doneAt", doneAt, 10);
    expQ = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hB};
    checkDump("overlapRead", 4'd0, 4'd5);

    $display("[TB] reset during WR of element 1");
    initMem();
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.src   = 4'd0;
    bus.dst   = 4'd8;
    bus.len   = 4'd4;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("abort_wrenBefore", int'(bus.dm_wren),    1);
    checkOutput("abort_addrBefore", int'(bus.dm_address), 9);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort_wren", int'(bus.dm_wren), 0);
    checkOutput("abort_busy", int'(bus.busy),    0);
    doneSeen = bus.done;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1 if (bus.done) doneSeen = 1'b1;
    end
    checkOutput("abort_noDone", int'(doneSeen), 0);
    expQ = '{4'hF, 4'hE, 4'h5, 4'h4};
    checkDump("abortRead", 4'd8, 4'd4);

    $display("[TB] start held high while busy");
    initMem();
    @(negedge clock);
    bus.start      = 1'b1;
    bus.op         = 2'b00;
    bus.dst        = 4'd0;
    bus.len        = 4'd4;
    bus.fill_value = 4'h3;
    @(posedge clock);
    #1;
    bus.op  = 2'b01;
    bus.src = 4'd8;
    bus.dst = 4'd12;
    bus.len = 4'd2;
    repeat (3) @(posedge clock);
    #1 bus.start = 1'b0;
    doneAt = -1;
    for (int k = 4; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        doneAt = k;
        break;
      end
    end
    checkOutput("busyStart_doneAt", doneAt, 5);
    busyDropped = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1 if (bus.busy || bus.done) busyDropped = 1'b1;
    end
    checkOutput("busyStart_noRelaunch", int'(busyDropped), 0);
    expQ = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hB};
    checkDump("busyStartRead", 4'd0, 4'd5);
    expQ = '{4'h3, 4'h2};
    checkDump("busyStartDst", 4'd12, 4'd2);

    $display("[TB] reserved op");
    applyStimulus(2'b11, 4'd0, 4'd0, 4'd5, 4'd0);
    checkOutput("reserved_doneAt", doneAt, 1);
    checkOutput("reserved_wren", int'(wrenSeen), 0);
    checkOutput("reserved_rdCount", rdQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
